// File: rtl/spi_slave_regfile.sv
// SPI slave register file: command/address framing, auto-increment bursts,
// RX FIFO for core write-back packets. Optional write lock: SPI_REGS_WPROT_EN.
module spi_slave_regfile #(
  parameter int NREGS = 64,
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int PW    = 104
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hw_en,
  input  logic               spi_cs,
  input  logic               spi_valid,
  input  logic [7:0]         spi_byte,
  output logic [7:0]         spi_rdata,
  output logic               spi_en,
  output logic               cpol,
  output logic               cpha,
  output logic               lsbfirst,
  output logic               irq,
  output logic [8*NREGS-1:0] spi_regs,
  input  logic               access_in,
  input  logic [PW-1:0]      packet_in,
  output logic               wait_out
);
  localparam int RAW = $clog2(NREGS);
  localparam int FAW = $clog2(DEPTH);
  localparam int LW  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDATA} state_t;

  state_t         state_q, state_d;
  logic [RAW-1:0] ptr_q;
  logic           rd_q, inc_q;
  logic [7:0]     config_q;
  logic           ovf_q, udf_q;
  logic [7:0]     user_q [16:NREGS-1];
  logic [63:0]    fifo_q [DEPTH];
  logic [FAW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]  level_q;
  logic [7:0]     view [NREGS];

  logic        active, take, wr_en, wr_cfg, wr_sts, locked;
  logic        pop_req, pop, push, full, empty;
  logic [63:0] entry, head;
  logic        unused_pkt;

`ifdef SPI_REGS_WPROT_EN
  assign locked = config_q[7];
`else
  assign locked = 1'b0;
`endif

  assign spi_en   = hw_en & ~config_q[0];
  assign cpol     = config_q[2];
  assign cpha     = config_q[3];
  assign lsbfirst = config_q[4];

  assign active  = spi_cs & spi_en;
  assign take    = active & spi_valid;
  assign wr_en   = take & (state_q == WDATA);
  assign wr_cfg  = wr_en & (ptr_q == '0) & ~locked;
  assign wr_sts  = wr_en & (ptr_q == RAW'(1));
  assign pop_req = take & (state_q == RDATA) & (ptr_q == RAW'(15));

  assign empty    = (level_q == '0);
  assign full     = (level_q == LW'(DEPTH));
  assign pop      = pop_req & ~empty;
  assign push     = access_in & (~full | pop);
  assign wait_out = full;
  assign irq      = config_q[1] & (~empty | ovf_q);

  // FIFO entry is {srcaddr[31:0], data[31:0]} from the emesh packet
  assign entry      = {packet_in[8+2*AW +: 32], packet_in[8+AW +: 32]};
  assign head       = fifo_q[rd_ptr_q];
  assign unused_pkt = ^packet_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!active) begin
      state_d = IDLE;
    end else if (spi_valid) begin
      case (state_q)
        IDLE:    state_d = ADDR;
        ADDR:    state_d = rd_q ? RDATA : WDATA;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      rd_q  <= 1'b0;
      inc_q <= 1'b0;
    end else if (take) begin
      case (state_q)
        IDLE: begin
          rd_q  <= spi_byte[7];
          inc_q <= spi_byte[6];
        end
        ADDR:    ptr_q <= spi_byte[RAW-1:0];
        default: if (inc_q) ptr_q <= ptr_q + 1'b1;
      endcase
    end
  end

  // Hardware set of a sticky bit takes priority over a same-cycle W1C
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      config_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (wr_cfg) config_q <= spi_byte;
      ovf_q <= (ovf_q & ~(wr_sts & spi_byte[1])) | (access_in & full & ~pop);
      udf_q <= (udf_q & ~(wr_sts & spi_byte[2])) | (pop_req & empty);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 16; i < NREGS; i++) user_q[i] <= '0;
    end else if (wr_en && !locked) begin
      for (int unsigned i = 16; i < NREGS; i++)
        if (ptr_q == RAW'(i)) user_q[i] <= spi_byte;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= entry;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push) level_q <= level_q - 1'b1;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) view[i] = '0;
    view[0] = config_q;
    view[1] = {5'b0, udf_q, ovf_q, ~empty};
    view[2] = 8'(level_q);
    for (int unsigned k = 0; k < 8; k++) view[8+k] = empty ? 8'h00 : head[8*k +: 8];
    for (int unsigned i = 16; i < NREGS; i++) view[i] = user_q[i];
  end

  always_comb begin
    spi_regs = '0;
    for (int unsigned i = 0; i < NREGS; i++) spi_regs[8*i +: 8] = view[i];
  end

  assign spi_rdata = view[ptr_q];

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Randomised bench for spi_slave_regfile against a transaction-level model,
// plus scripted scenarios with literal expectations.
module tb_spi_slave_regfile;
  localparam int NREGS = 64;
  localparam int DEPTH = 4;
  localparam int PW    = 104;

  logic               clk = 1'b0;
  logic               reset, hw_en, spi_cs, spi_valid, access_in;
  logic [7:0]         spi_byte, spi_rdata;
  logic               spi_en, cpol, cpha, lsbfirst, irq, wait_out;
  logic [8*NREGS-1:0] spi_regs;
  logic [PW-1:0]      packet_in;

  int tests = 0;
  int fails = 0;
  bit checking = 0;
  bit rand_acc = 0;

  spi_slave_regfile #(.NREGS(NREGS), .DEPTH(DEPTH), .AW(32), .PW(PW)) dut (
    .clk(clk), .reset(reset), .hw_en(hw_en), .spi_cs(spi_cs),
    .spi_valid(spi_valid), .spi_byte(spi_byte), .spi_rdata(spi_rdata),
    .spi_en(spi_en), .cpol(cpol), .cpha(cpha), .lsbfirst(lsbfirst),
    .irq(irq), .spi_regs(spi_regs), .access_in(access_in),
    .packet_in(packet_in), .wait_out(wait_out)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [7:0]  m_cfg;
  logic [7:0]  m_user [NREGS];
  logic        m_ovf, m_udf;
  logic [63:0] m_q [$];
  int          m_idx, m_ptr;
  logic [7:0]  m_cmd;

  task automatic m_reset();
    m_cfg = 0; m_ovf = 0; m_udf = 0; m_idx = 0; m_ptr = 0; m_cmd = 0;
    m_q.delete();
    for (int i = 0; i < NREGS; i++) m_user[i] = 0;
  endtask

  function automatic logic [7:0] m_view(input int a);
    if (a == 0) return m_cfg;
    if (a == 1) return {5'b0, m_udf, m_ovf, m_q.size() != 0};
    if (a == 2) return 8'(m_q.size());
    if (a < 8) return 8'h00;
    if (a < 16) return (m_q.size() == 0) ? 8'h00 : m_q[0][8*(a-8) +: 8];
    return m_user[a];
  endfunction

  task automatic m_write(input int a, input logic [7:0] d);
    bit locked;
`ifdef SPI_REGS_WPROT_EN
    locked = m_cfg[7];
`else
    locked = 0;
`endif
    if (a == 0) begin
      if (!locked) m_cfg = d;
    end else if (a == 1) begin
      if (d[1]) m_ovf = 0;
      if (d[2]) m_udf = 0;
    end else if (a >= 16) begin
      if (!locked) m_user[a] = d;
    end
  endtask

  task automatic m_step();
    bit act, pop_req, was_full, popped;
    act = spi_cs && hw_en && !m_cfg[0];
    pop_req = 0; popped = 0;
    if (!act) m_idx = 0;
    else if (spi_valid) begin
      if (m_idx == 0) begin m_cmd = spi_byte; m_idx = 1; end
      else if (m_idx == 1) begin m_ptr = int'(spi_byte) % NREGS; m_idx = 2; end
      else begin
        if (m_cmd[7]) pop_req = (m_ptr == 15);
        else m_write(m_ptr, spi_byte);
        if (m_cmd[6]) m_ptr = (m_ptr + 1) % NREGS;
      end
    end
    was_full = (m_q.size() == DEPTH);
    if (pop_req) begin
      if (m_q.size() == 0) m_udf = 1;
      else begin m_q.delete(0); popped = 1; end
    end
    if (access_in) begin
      if (!was_full || popped) m_q.push_back({packet_in[103:72], packet_in[71:40]});
      else m_ovf = 1;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) m_reset();
      else m_step();
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [8*NREGS-1:0] got, input logic [8*NREGS-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  initial begin
    logic [8*NREGS-1:0] ev;
    forever begin
      @(negedge clk);
      if (checking) begin
        for (int i = 0; i < NREGS; i++) ev[8*i +: 8] = m_view(i);
        check("spi_regs", spi_regs, ev);
        check("spi_rdata", spi_rdata, m_view(m_ptr));
        check("irq", irq, m_cfg[1] & ((m_q.size() != 0) | m_ovf));
        check("wait_out", wait_out, m_q.size() == DEPTH);
        check("spi_en", spi_en, hw_en & ~m_cfg[0]);
        check("cfg_bits", {cpol, cpha, lsbfirst}, {m_cfg[2], m_cfg[3], m_cfg[4]});
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    if (rand_acc) begin
      access_in = ($urandom_range(0, 2) == 0);
      packet_in = PW'({$urandom(), $urandom(), $urandom(), $urandom()});
    end
    @(posedge clk); #2;
  endtask

  task automatic send(input logic [7:0] b);
    spi_byte = b; spi_valid = 1; tick(); spi_valid = 0;
    repeat ($urandom_range(0, 1)) tick();
  endtask

  task automatic cs_begin(); spi_cs = 1; tick(); endtask
  task automatic cs_end();   spi_cs = 0; tick(); endtask

  task automatic do_reset(); reset = 1; tick(); reset = 0; tick(); endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    cs_begin(); send(8'h00); send(a); send(d); cs_end();
  endtask

  task automatic push_pkt(input logic [31:0] src, input logic [31:0] data);
    packet_in = '0; packet_in[72 +: 32] = src; packet_in[40 +: 32] = data;
    access_in = 1; tick(); access_in = 0;
  endtask

  function automatic logic [7:0] reg_at(input int i);
    return spi_regs[8*i +: 8];
  endfunction

  // ---------------- scenarios ----------------
  initial begin
    reset = 1; hw_en = 1; spi_cs = 0; spi_valid = 0; spi_byte = 0;
    access_in = 0; packet_in = '0;
    repeat (2) tick();
    reset = 0; tick();
    checking = 1;
    check("reset_rdata", spi_rdata, 8'h00);
    check("reset_spi_en", spi_en, 1'b1);

    // reset in the middle of a write burst
    cs_begin(); send(8'h40); send(8'h10); send(8'h5A); send(8'h6B);
    check("mid_reg16", reg_at(16), 8'h5A);
    check("mid_reg17", reg_at(17), 8'h6B);
    reset = 1; tick();
    check("rst_reg16", reg_at(16), 8'h00);
    check("rst_rdata", spi_rdata, 8'h00);
    check("rst_irq", irq, 1'b0);
    reset = 0; tick();
    send(8'h00); send(8'h13); send(8'h99); cs_end();
    check("post_rst_idle", reg_at(19), 8'h99);

    // auto-increment write then fixed-address read
    cs_begin(); send(8'h40); send(8'h10); send(8'hA1); send(8'hB2); send(8'hC3); cs_end();
    check("burst16", reg_at(16), 8'hA1);
    check("burst17", reg_at(17), 8'hB2);
    check("burst18", reg_at(18), 8'hC3);
    cs_begin(); send(8'h80); send(8'h11);
    for (int k = 0; k < 3; k++) begin
      check("noinc_read", spi_rdata, 8'hB2);
      send(8'h00);
    end
    cs_end();

    // pointer wrap
    cs_begin(); send(8'h40); send(8'(NREGS - 1)); send(8'h11); send(8'h22); cs_end();
    check("wrap_top", reg_at(NREGS - 1), 8'h11);
    check("wrap_cfg", reg_at(0), 8'h22);

    // FIFO overflow, irq, burst window read
    wr_reg(8'h00, 8'h02);
    push_pkt(32'h88776655, 32'h44332211);
    for (int i = 1; i < 5; i++) push_pkt(32'(i * 3), 32'(i * 7));
    check("ovf_wait", wait_out, 1'b1);
    check("ovf_count", reg_at(2), 8'h04);
    check("ovf_status", reg_at(1), 8'h03);
    check("ovf_irq", irq, 1'b1);
    cs_begin(); send(8'hC0); send(8'h08);
    for (int k = 0; k < 8; k++) begin
      check("window", spi_rdata, 8'(8'h11 * (k + 1)));
      send(8'h00);
    end
    cs_end();
    check("pop_count", reg_at(2), 8'h03);
    check("pop_wait", wait_out, 1'b0);
    wr_reg(8'h01, 8'h02);
    check("w1c_ovf", reg_at(1), 8'h01);

    // simultaneous push and pop at full, then underflow
    push_pkt(32'h1, 32'h2);
    check("refill", reg_at(2), 8'h04);
    cs_begin(); send(8'h80); send(8'h0F);
    packet_in = '0; packet_in[72 +: 32] = 32'hCAFE0000; access_in = 1;
    spi_byte = 8'h00; spi_valid = 1; tick(); spi_valid = 0; access_in = 0;
    check("pp_count", reg_at(2), 8'h04);
    check("pp_status", reg_at(1), 8'h01);
    for (int k = 0; k < 4; k++) send(8'h00);
    cs_end();
    check("drained", reg_at(2), 8'h00);
    cs_begin(); send(8'hC0); send(8'h08);
    for (int k = 0; k < 8; k++) begin
      check("empty_window", spi_rdata, 8'h00);
      send(8'h00);
    end
    cs_end();
    check("udf_status", reg_at(1), 8'h04);
    check("udf_irq", irq, 1'b0);
    wr_reg(8'h01, 8'h04);
    check("w1c_udf", reg_at(1), 8'h00);

    // chip select dropped after the command byte
    cs_begin(); send(8'h40); cs_end();
    cs_begin(); send(8'h00); send(8'h14); send(8'h77); cs_end();
    check("cs_abort", reg_at(20), 8'h77);

    // disable bit blocks the port until reset
    wr_reg(8'h00, 8'h01);
    check("disabled", spi_en, 1'b0);
    wr_reg(8'h14, 8'hEE);
    check("disabled_ignore", reg_at(20), 8'h77);
    do_reset();
    check("reenabled", spi_en, 1'b1);

    // write lock
    wr_reg(8'h00, 8'h80);
    wr_reg(8'h14, 8'h55);
`ifdef SPI_REGS_WPROT_EN
    check("locked_reg20", reg_at(20), 8'h00);
`else
    check("unlocked_reg20", reg_at(20), 8'h55);
`endif
    do_reset();
    wr_reg(8'h14, 8'h55);
    check("after_rst_reg20", reg_at(20), 8'h55);

    // randomised transactions
    rand_acc = 1;
    for (int t = 0; t < 250; t++) begin
      logic [7:0] cmd, addr;
      int len;
      if (t % 40 == 0) do_reset();
      hw_en = ($urandom_range(0, 15) != 0);
      cmd  = 8'($urandom());
      addr = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom());
      len  = $urandom_range(0, 6);
      cs_begin();
      send(cmd);
      if ($urandom_range(0, 7) != 0) begin
        send(addr);
        for (int k = 0; k < len; k++) send(8'($urandom()));
      end
      cs_end();
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_acc = 0; access_in = 0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
